// File: rtl/crc5_check.sv
// Receive-side USB CRC5 checker: runs the x^5+x^2+1 LFSR over payload plus
// transmitted CRC bits and flags a good packet when the fixed residue is left.
module crc5_check #(
    parameter int unsigned DATA_BITS   = 11,
    parameter logic [4:0]  CRC_INIT    = 5'b11111,
    parameter logic [4:0]  CRC_RESIDUE = 5'b01100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       chk_start,
    input  logic       bit_valid,
    input  logic       s_in,
    input  logic       chk_ack,
    output logic       chk_busy,
    output logic       chk_done,
    output logic       chk_ok,
    output logic [4:0] crc_q
);

    localparam int unsigned   CW        = $clog2(DATA_BITS + 6);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_CRC  = CW'(DATA_BITS + 4);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          ok_q;
    logic          fb;
    logic [4:0]    crc_d;

    assign fb    = s_in ^ crc_q[4];
    assign crc_d = {crc_q[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);

    // A start pulse always wins: it restarts from any state and drops any
    // bit presented in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else if (chk_start) begin
            state_q <= DATA;
            crc_q   <= CRC_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                end
                DATA: begin
                    if (bit_valid) begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == LAST_DATA) begin
                            state_q <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (bit_valid) begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == LAST_CRC) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ok_q    <= (crc_d == CRC_RESIDUE);
                        end
                    end
                end
                DONE: begin
                    if (chk_ack) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        ok_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ok_q    <= 1'b0;
                end
            endcase
        end
    end

    assign chk_busy = busy_q;
    assign chk_done = done_q;
    assign chk_ok   = ok_q;

endmodule

// File: tb/tb_crc5_check.sv
// Bench for crc5_check: directed and random packets, scoreboard of expected
// {ok, crc} results checked when chk_done rises.
module tb_crc5_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       chk_start;
    logic       bit_valid;
    logic       s_in;
    logic       chk_ack;
    logic       chk_busy;
    logic       chk_done;
    logic       chk_ok;
    logic [4:0] crc_q;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_push = 0;
    logic [5:0] exp_q[$];
    logic       prev_done = 1'b0;

    // Wire order, bit 0 first: payload 0000_1000_111 then CRC 10100.
    localparam logic [15:0] GOOD    = 16'b0010_1111_0001_0000;
    localparam logic [15:0] BAD     = 16'b1010_1111_0001_0000;
    localparam logic [4:0]  RESIDUE = 5'b01100;

    crc5_check dut (
        .clk       (clk),
        .rst       (rst),
        .chk_start (chk_start),
        .bit_valid (bit_valid),
        .s_in      (s_in),
        .chk_ack   (chk_ack),
        .chk_busy  (chk_busy),
        .chk_done  (chk_done),
        .chk_ok    (chk_ok),
        .crc_q     (crc_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] model_crc(input logic [15:0] pkt, input int n);
        logic [4:0] c;
        logic       f;
        c = 5'b11111;
        for (int i = 0; i < n; i++) begin
            f = pkt[i] ^ c[4];
            c = {c[3:0], 1'b0} ^ (f ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    task automatic start_pkt;
        chk_start = 1'b1;
        tick();
        chk_start = 1'b0;
    endtask

    task automatic drive_bits(input logic [15:0] pkt, input int lo, input int hi, input bit gapped);
        logic [4:0] snap;
        int         g;
        for (int i = lo; i < hi; i++) begin
            s_in      = pkt[i];
            bit_valid = 1'b1;
            tick();
            bit_valid = 1'b0;
            if (gapped && i != hi - 1) begin
                snap = crc_q;
                g    = $urandom_range(1, 3);
                repeat (g) begin
                    s_in = 1'($urandom_range(0, 1));
                    tick();
                    check("gap_crc_frozen", crc_q, snap);
                    check("gap_busy", chk_busy, 1);
                end
            end
        end
    endtask

    task automatic push_expect(input logic [15:0] pkt);
        logic [4:0] c;
        c = model_crc(pkt, 16);
        exp_q.push_back({c == RESIDUE, c});
        n_push++;
    endtask

    task automatic send_packet(input logic [15:0] pkt, input bit gapped);
        push_expect(pkt);
        drive_bits(pkt, 0, 16, gapped);
    endtask

    task automatic finish_pkt;
        check("done_before_ack", chk_done, 1);
        chk_ack = 1'b1;
        tick();
        chk_ack = 1'b0;
        check("done_after_ack", chk_done, 0);
        check("ok_after_ack", chk_ok, 0);
    endtask

    // Scoreboard: compare against the oldest expected result on each rising done.
    always @(negedge clk) begin
        logic [5:0] e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (chk_done && !prev_done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("done_with_empty_queue", chk_done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", {chk_ok, crc_q}, e);
                end
            end
            prev_done = chk_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pkt;
        logic [4:0]  c;
        logic [4:0]  inv;

        rst = 1'b1; chk_start = 1'b0; bit_valid = 1'b0; s_in = 1'b0; chk_ack = 1'b0;
        tick(); tick();
        check("rst_crc", crc_q, 5'b11111);
        check("rst_busy", chk_busy, 0);
        check("rst_done", chk_done, 0);
        check("rst_ok", chk_ok, 0);
        rst = 1'b0;
        tick();

        // IDLE ignores bits.
        s_in = 1'b1; bit_valid = 1'b1;
        tick(); tick();
        bit_valid = 1'b0;
        check("idle_crc", crc_q, 5'b11111);
        check("idle_busy", chk_busy, 0);

        // Asynchronous reset mid-packet, observed before any clock edge.
        start_pkt();
        drive_bits(GOOD, 0, 5, 1'b0);
        check("mid_crc_5bits", crc_q, model_crc(GOOD, 5));
        #2 rst = 1'b1;
        #1;
        check("async_rst_crc", crc_q, 5'b11111);
        check("async_rst_busy", chk_busy, 0);
        check("async_rst_done", chk_done, 0);
        check("async_rst_ok", chk_ok, 0);
        #1 rst = 1'b0;
        tick();

        // Good packet with known intermediate and final values.
        start_pkt();
        check("start_busy", chk_busy, 1);
        check("start_crc", crc_q, 5'b11111);
        push_expect(GOOD);
        drive_bits(GOOD, 0, 11, 1'b0);
        check("good_payload_crc", crc_q, 5'b01011);
        drive_bits(GOOD, 11, 16, 1'b0);
        check("good_done", chk_done, 1);
        check("good_ok", chk_ok, 1);
        check("good_crc", crc_q, 5'b01100);
        check("good_busy", chk_busy, 0);
        repeat (3) tick();
        check("good_done_held", chk_done, 1);
        finish_pkt();
        check("good_crc_retained", crc_q, 5'b01100);

        // Corrupt CRC field.
        start_pkt();
        send_packet(BAD, 1'b0);
        check("bad_ok", chk_ok, 0);
        check("bad_crc", crc_q, 5'b01001);
        finish_pkt();

        // Gapped good packet.
        start_pkt();
        send_packet(GOOD, 1'b1);
        check("gapped_ok", chk_ok, 1);
        check("gapped_crc", crc_q, 5'b01100);
        finish_pkt();

        // Abort after 6 bits with a start coincident with a valid bit.
        start_pkt();
        drive_bits(BAD, 0, 6, 1'b0);
        chk_start = 1'b1; bit_valid = 1'b1; s_in = 1'b1;
        tick();
        chk_start = 1'b0; bit_valid = 1'b0;
        check("abort_crc", crc_q, 5'b11111);
        check("abort_busy", chk_busy, 1);
        chk_ack = 1'b1;
        tick();
        chk_ack = 1'b0;
        check("ack_in_data_busy", chk_busy, 1);
        send_packet(GOOD, 1'b0);
        check("abort_then_good_ok", chk_ok, 1);

        // bit_valid held through DONE must not move crc_q.
        bit_valid = 1'b1; s_in = 1'b1;
        tick(); tick();
        bit_valid = 1'b0;
        check("done_bits_ignored_crc", crc_q, 5'b01100);
        check("done_bits_ignored_done", chk_done, 1);

        // Start and ack together in DONE: start wins, back-to-back packet follows.
        chk_start = 1'b1; chk_ack = 1'b1;
        tick();
        chk_start = 1'b0; chk_ack = 1'b0;
        check("race_busy", chk_busy, 1);
        check("race_done", chk_done, 0);
        check("race_ok", chk_ok, 0);
        check("race_crc", crc_q, 5'b11111);
        send_packet(BAD, 1'b0);
        start_pkt();
        check("b2b_restart_done", chk_done, 0);
        send_packet(GOOD, 1'b1);
        finish_pkt();

        // Random payloads; even ones carry the correct inverted-remainder CRC.
        for (int k = 0; k < 6; k++) begin
            pkt = 16'($urandom);
            if (k % 2 == 0) begin
                c   = model_crc(pkt, 11);
                inv = ~c;
                for (int j = 0; j < 5; j++) pkt[11 + j] = inv[4 - j];
            end
            start_pkt();
            send_packet(pkt, 1'b1);
            if (k % 2 == 0) check("rand_good_ok", chk_ok, 1);
            finish_pkt();
        end

        tick(); tick();
        check("done_count", n_done, n_push);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
